// File: rtl/bus_cycle_engine.sv
// Sequences M-cycles of T-states for one instruction and drives the registered memory bus.
// Define BCE_WAIT_STATE_EN to let mem_ready insert wait states at T3.
module bus_cycle_engine #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 8,
  parameter int MAX_CYCLES = 6,
  parameter int T_PER_M    = 4,
  localparam int CNT_W     = $clog2(MAX_CYCLES) + 1,
  localparam int IDX_W     = $clog2(MAX_CYCLES)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [CNT_W-1:0]  instr_num_cycles,
  output logic [IDX_W-1:0]  cycle_idx,
  input  logic [1:0]        cyc_op,
  input  logic [ADDR_W-1:0] cyc_addr,
  input  logic [DATA_W-1:0] cyc_wdata,
  input  logic              cyc_cond_check,
  input  logic              cond_true,
  output logic [ADDR_W-1:0] addr_bus,
  output logic [DATA_W-1:0] wdata,
  output logic              drive_data,
  output logic              mem_req_read,
  output logic              mem_req_write,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic [DATA_W-1:0] rdata_q,
  output logic [2:0]        t_phase,
  output logic              instr_done
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [2:0]       PH_T1   = 3'd0;
  localparam logic [2:0]       PH_T2   = 3'd1;
  localparam logic [2:0]       PH_T3   = 3'd2;
  localparam logic [2:0]       PH_LAST = 3'(T_PER_M - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(MAX_CYCLES - 1);

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [IDX_W-1:0]    last_q, last_d;
  logic [2:0]          phase_q, phase_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdq_q, rdq_d;
  logic                rd_q, rd_d;
  logic                wr_q, wr_d;
  logic                drv_q, drv_d;
  logic                rvld_q, rvld_d;
  logic                done_q, done_d;

  logic                ready_eff;
  logic                is_read;
  logic                is_write;
  logic                cond_fail;
  logic [IDX_W-1:0]    acc_last;

`ifdef BCE_WAIT_STATE_EN
  assign ready_eff = mem_ready;
`else
  // Without wait states the memory is always considered ready.
  assign ready_eff = mem_ready | 1'b1;
`endif

  assign is_read   = (cyc_op == 2'd1);
  assign is_write  = (cyc_op == 2'd2);
  assign cond_fail = cyc_cond_check & ~cond_true;

  // Stored as the index of the last M-cycle: 0 behaves as 1, oversize clamps to the maximum.
  always_comb begin
    acc_last = '0;
    if (instr_num_cycles == '0) begin
      acc_last = '0;
    end else if (instr_num_cycles > CNT_W'(MAX_CYCLES)) begin
      acc_last = IDX_MAX;
    end else begin
      acc_last = IDX_W'(instr_num_cycles - CNT_W'(1));
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    phase_d = phase_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdq_d   = rdq_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    drv_d   = drv_q;
    rvld_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (instr_valid) begin
          state_d = RUN;
          idx_d   = '0;
          phase_d = PH_T1;
          last_d  = acc_last;
        end
      end

      RUN: begin
        if (phase_q == PH_LAST) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          drv_d   = 1'b0;
          phase_d = PH_T1;
          // A failed condition skips straight to the final M-cycle slot.
          if (cond_fail && (idx_q != IDX_MAX)) begin
            idx_d = IDX_MAX;
          end else if (cond_fail || (idx_q == last_q) || (idx_q == IDX_MAX)) begin
            state_d = IDLE;
            idx_d   = '0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else if (phase_q == PH_T1) begin
          addr_d  = cyc_addr;
          phase_d = PH_T2;
        end else if (phase_q == PH_T2) begin
          if (is_read) begin
            rd_d  = 1'b1;
            drv_d = 1'b0;
          end else if (is_write) begin
            wr_d    = 1'b1;
            drv_d   = 1'b1;
            wdata_d = cyc_wdata;
          end
          phase_d = PH_T3;
        end else if (phase_q == PH_T3) begin
          if (!((is_read || is_write) && !ready_eff)) begin
            if (is_read) begin
              rdq_d  = rdata;
              rvld_d = 1'b1;
            end
            phase_d = phase_q + 3'd1;
          end
        end else begin
          phase_d = phase_q + 3'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      last_q  <= '0;
      phase_q <= PH_T1;
      addr_q  <= '0;
      wdata_q <= '0;
      rdq_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      drv_q   <= 1'b0;
      rvld_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      phase_q <= phase_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdq_q   <= rdq_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      drv_q   <= drv_d;
      rvld_q  <= rvld_d;
      done_q  <= done_d;
    end
  end

  assign instr_ready   = (state_q == IDLE);
  assign cycle_idx     = idx_q;
  assign t_phase       = phase_q;
  assign addr_bus      = addr_q;
  assign wdata         = wdata_q;
  assign drive_data    = drv_q;
  assign mem_req_read  = rd_q;
  assign mem_req_write = wr_q;
  assign rdata_valid   = rvld_q;
  assign rdata_q       = rdq_q;
  assign instr_done    = done_q;

endmodule

// File: tb/tb_bus_cycle_engine.sv
// Randomized bench for bus_cycle_engine, checked against a transaction-level model.
module tb_bus_cycle_engine;
  localparam int AW   = 16;
  localparam int DW   = 8;
  localparam int MAXC = 6;
  localparam int TPM  = 4;
  localparam int CW   = $clog2(MAXC) + 1;
  localparam int IW   = $clog2(MAXC);
`ifdef BCE_WAIT_STATE_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          instr_valid = 1'b0;
  logic          instr_ready;
  logic [CW-1:0] instr_num_cycles = '0;
  logic [IW-1:0] cycle_idx;
  logic [1:0]    cyc_op;
  logic [AW-1:0] cyc_addr;
  logic [DW-1:0] cyc_wdata;
  logic          cyc_cond_check;
  logic          cond_true;
  logic [AW-1:0] addr_bus;
  logic [DW-1:0] wdata;
  logic          drive_data, mem_req_read, mem_req_write;
  logic          mem_ready;
  logic [DW-1:0] rdata;
  logic          rdata_valid;
  logic [DW-1:0] rdata_q;
  logic [2:0]    t_phase;
  logic          instr_done;

  bus_cycle_engine #(.ADDR_W(AW), .DATA_W(DW), .MAX_CYCLES(MAXC), .T_PER_M(TPM)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_num_cycles(instr_num_cycles), .cycle_idx(cycle_idx), .cyc_op(cyc_op),
    .cyc_addr(cyc_addr), .cyc_wdata(cyc_wdata), .cyc_cond_check(cyc_cond_check),
    .cond_true(cond_true), .addr_bus(addr_bus), .wdata(wdata), .drive_data(drive_data),
    .mem_req_read(mem_req_read), .mem_req_write(mem_req_write), .mem_ready(mem_ready),
    .rdata(rdata), .rdata_valid(rdata_valid), .rdata_q(rdata_q), .t_phase(t_phase),
    .instr_done(instr_done)
  );

  always #5 clk = ~clk;

  // Per-M-cycle control words ("microcode") indexed by cycle_idx.
  logic [1:0]    p_op[8];
  logic [AW-1:0] p_addr[8];
  logic [DW-1:0] p_wd[8];
  logic [DW-1:0] p_rd[8];
  logic          p_cc[8];
  logic          p_ct[8];
  int            p_wait[8];

  always_comb begin
    cyc_op         = p_op[cycle_idx];
    cyc_addr       = p_addr[cycle_idx];
    cyc_wdata      = p_wd[cycle_idx];
    cyc_cond_check = p_cc[cycle_idx];
    cond_true      = p_ct[cycle_idx];
    rdata          = p_rd[cycle_idx];
  end

  // Memory holds mem_ready low for p_wait clocks once T3 is reached.
  int stall_left = 0;
  always @(posedge clk) begin
    if (!instr_ready && t_phase == 3'd1) stall_left <= p_wait[cycle_idx];
    else if (t_phase == 3'd2 && stall_left != 0) stall_left <= stall_left - 1;
  end
  assign mem_ready = !(t_phase == 3'd2 && stall_left != 0);

  // Bus monitor
  int            obs_idx[$];
  logic [AW-1:0] obs_raddr[$], obs_waddr[$];
  logic [DW-1:0] obs_rdq[$], obs_wd[$];
  int            proto_err = 0;
  logic          prev_rd = 1'b0, prev_wr = 1'b0, prev_vld = 1'b0, prev_done = 1'b0;
  logic [AW-1:0] held_addr = '0;

  always @(negedge clk) begin
    if (!instr_ready && t_phase == 3'd0) obs_idx.push_back(int'(cycle_idx));
    if (mem_req_read && !prev_rd) begin
      obs_raddr.push_back(addr_bus);
      held_addr <= addr_bus;
    end else if (mem_req_write && !prev_wr) begin
      obs_waddr.push_back(addr_bus);
      obs_wd.push_back(wdata);
      held_addr <= addr_bus;
    end else if ((mem_req_read || mem_req_write) && addr_bus != held_addr) begin
      proto_err <= proto_err + 1;
    end
    if (rdata_valid) obs_rdq.push_back(rdata_q);
    if ((mem_req_read && (drive_data || mem_req_write)) || (mem_req_write && !drive_data) ||
        (t_phase < 3'd2 && (mem_req_read || mem_req_write || drive_data)) ||
        (rdata_valid && prev_vld) || (instr_done && prev_done))
      proto_err <= proto_err + 1;
    prev_rd   <= mem_req_read;
    prev_wr   <= mem_req_write;
    prev_vld  <= rdata_valid;
    prev_done <= instr_done;
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Transaction-level expectation for one instruction.
  int            exp_idx[$];
  logic [AW-1:0] exp_raddr[$], exp_waddr[$];
  logic [DW-1:0] exp_rd[$], exp_wd[$];
  int            exp_lat;

  task automatic build_expect(input int cnt);
    int last;
    int i;
    exp_idx.delete(); exp_raddr.delete(); exp_waddr.delete(); exp_rd.delete(); exp_wd.delete();
    exp_lat = 0;
    last = (cnt == 0) ? 0 : ((cnt > MAXC) ? MAXC - 1 : cnt - 1);
    i = 0;
    for (int step = 0; step < 2 * MAXC; step++) begin
      exp_idx.push_back(i);
      exp_lat += TPM + ((WAIT_EN && (p_op[i] == 2'd1 || p_op[i] == 2'd2)) ? p_wait[i] : 0);
      if (p_op[i] == 2'd1) begin exp_raddr.push_back(p_addr[i]); exp_rd.push_back(p_rd[i]); end
      if (p_op[i] == 2'd2) begin exp_waddr.push_back(p_addr[i]); exp_wd.push_back(p_wd[i]); end
      if (p_cc[i] && !p_ct[i]) begin
        if (i == MAXC - 1) break;
        i = MAXC - 1;
      end else if (i == last || i == MAXC - 1) begin
        break;
      end else begin
        i++;
      end
    end
  endtask

  task automatic clear_prog();
    for (int k = 0; k < 8; k++) begin
      p_op[k] = 2'd0; p_addr[k] = '0; p_wd[k] = '0; p_rd[k] = '0;
      p_cc[k] = 1'b0; p_ct[k] = 1'b0; p_wait[k] = 0;
    end
  endtask

  task automatic rand_prog();
    for (int k = 0; k < 8; k++) begin
      p_op[k]   = 2'($urandom_range(0, 3));
      p_addr[k] = AW'($urandom);
      p_wd[k]   = DW'($urandom);
      p_rd[k]   = DW'($urandom);
      p_cc[k]   = ($urandom_range(0, 3) == 0);
      p_ct[k]   = 1'($urandom);
      p_wait[k] = $urandom_range(0, 3);
    end
  endtask

  // Offer one instruction, run it to instr_done and compare with the model.
  task automatic run_instr(input int cnt, input string name);
    int g;
    int lat;
    int e0;
    bit done;
    build_expect(cnt);
    g = 0;
    while (!instr_ready && g < 100) begin @(negedge clk); g++; end
    if (!instr_ready) chk({name, ":ready_timeout"}, 32'(instr_ready), 32'd1);
    instr_valid = 1'b1;
    instr_num_cycles = CW'(cnt);
    @(posedge clk);
    obs_idx.delete(); obs_raddr.delete(); obs_waddr.delete(); obs_rdq.delete(); obs_wd.delete();
    e0 = proto_err;
    @(negedge clk);
    chk({name, ":busy"}, 32'(instr_ready), 32'd0);
    lat = 0;
    done = 1'b0;
    while (!done && lat < 300) begin
      instr_valid = 1'($urandom);
      instr_num_cycles = CW'($urandom);
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (instr_done) done = 1'b1;
    end
    instr_valid = 1'b0;
    chk({name, ":latency"}, 32'(lat), 32'(exp_lat));
    chk({name, ":ready_at_done"}, 32'(instr_ready), 32'd1);
    chk({name, ":n_cycles"}, 32'(obs_idx.size()), 32'(exp_idx.size()));
    for (int k = 0; k < exp_idx.size() && k < obs_idx.size(); k++)
      chk($sformatf("%s:idx%0d", name, k), 32'(obs_idx[k]), 32'(exp_idx[k]));
    chk({name, ":n_reads"}, 32'(obs_raddr.size()), 32'(exp_raddr.size()));
    chk({name, ":n_rvalid"}, 32'(obs_rdq.size()), 32'(exp_rd.size()));
    for (int k = 0; k < exp_raddr.size() && k < obs_raddr.size() && k < obs_rdq.size(); k++) begin
      chk($sformatf("%s:raddr%0d", name, k), 32'(obs_raddr[k]), 32'(exp_raddr[k]));
      chk($sformatf("%s:rdata%0d", name, k), 32'(obs_rdq[k]), 32'(exp_rd[k]));
    end
    chk({name, ":n_writes"}, 32'(obs_waddr.size()), 32'(exp_waddr.size()));
    for (int k = 0; k < exp_waddr.size() && k < obs_waddr.size(); k++) begin
      chk($sformatf("%s:waddr%0d", name, k), 32'(obs_waddr[k]), 32'(exp_waddr[k]));
      chk($sformatf("%s:wdata%0d", name, k), 32'(obs_wd[k]), 32'(exp_wd[k]));
    end
    chk({name, ":protocol"}, 32'(proto_err - e0), 32'd0);
  endtask

  task automatic check_reset_state(input string name);
    chk({name, ":ready"}, 32'(instr_ready), 32'd1);
    chk({name, ":rd"}, 32'(mem_req_read), 32'd0);
    chk({name, ":wr"}, 32'(mem_req_write), 32'd0);
    chk({name, ":drv"}, 32'(drive_data), 32'd0);
    chk({name, ":phase"}, 32'(t_phase), 32'd0);
    chk({name, ":idx"}, 32'(cycle_idx), 32'd0);
    chk({name, ":addr"}, 32'(addr_bus), 32'd0);
    chk({name, ":wdata"}, 32'(wdata), 32'd0);
    chk({name, ":rdq"}, 32'(rdata_q), 32'd0);
    chk({name, ":rvld"}, 32'(rdata_valid), 32'd0);
    chk({name, ":done"}, 32'(instr_done), 32'd0);
  endtask

  // Start a one-cycle instruction and assert reset once it reaches the given phase.
  task automatic reset_mid(input logic [1:0] op, input int phase, input string name);
    int g;
    clear_prog();
    p_op[0] = op; p_addr[0] = 16'h1234; p_wd[0] = 8'hA5; p_rd[0] = 8'h3C; p_wait[0] = 3;
    instr_valid = 1'b1;
    instr_num_cycles = CW'(1);
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    g = 0;
    while (int'(t_phase) != phase && g < 20) begin @(negedge clk); g++; end
    chk({name, ":reached_phase"}, 32'(t_phase), 32'(phase));
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_state(name);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk({name, ":ready_after"}, 32'(instr_ready), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", n_chk, n_err);
    $fatal(1);
  end

  initial begin
    clear_prog();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state("por");
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("por:ready_after", 32'(instr_ready), 32'd1);

    // READ / WRITE / NONE, no wait states
    clear_prog();
    p_op[0] = 2'd1; p_addr[0] = 16'h0100; p_rd[0] = 8'hC3;
    p_op[1] = 2'd2; p_addr[1] = 16'hC000; p_wd[1] = 8'h5A;
    run_instr(3, "rwn");

    // single READ with three stalled clocks at T3
    clear_prog();
    p_op[0] = 2'd1; p_addr[0] = 16'h0150; p_rd[0] = 8'h77; p_wait[0] = 3;
    run_instr(1, "wait3");

    // failed condition in cycle 1 jumps to the last slot
    rand_prog();
    for (int k = 0; k < 8; k++) p_cc[k] = 1'b0;
    p_cc[1] = 1'b1; p_ct[1] = 1'b0;
    for (int k = 0; k < 8; k++) p_wait[k] = 0;
    run_instr(5, "cond_jump");
    chk("cond_jump:lat12", 32'(exp_lat), 32'd12);

    // count clamping, issued back to back
    rand_prog();
    for (int k = 0; k < 8; k++) p_cc[k] = 1'b0;
    run_instr(0, "cnt0");
    run_instr(9, "cnt9");

    reset_mid(2'd2, 1, "rst_write_t2");
    reset_mid(2'd1, 2, "rst_read_t3");

    for (int n = 0; n < 40; n++) begin
      rand_prog();
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_instr($urandom_range(0, 9), $sformatf("rnd%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/bus_cycle_engine.md
BUS_CYCLE_ENGINE -- requirements
Module: bus_cycle_engine

Interface
REQ-001 Parameter ADDR_W, default 16, address bus width.
REQ-002 Parameter DATA_W, default 8, data bus width.
REQ-003 Parameter MAX_CYCLES, default 6, maximum M-cycles per instruction, legal range 2..16.
REQ-004 Parameter T_PER_M, default 4, T-states per M-cycle, legal range 4..8.
REQ-005 Port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-006 Port reset, input, 1, synchronous active-high reset.
REQ-007 Port instr_valid / instr_ready, input / output, 1 / 1, instruction-accept handshake.
REQ-008 Port instr_num_cycles, input, $clog2(MAX_CYCLES)+1, M-cycle count of the offered instruction.
REQ-009 Port cycle_idx, output, $clog2(MAX_CYCLES), index of the current M-cycle; used to look up that cycle's control word.
REQ-010 Port cyc_op, input, 2, control word bus op: 0=NONE (ALU-only), 1=READ, 2=WRITE, 3=reserved (treated as NONE).
REQ-011 Ports cyc_addr, input, ADDR_W and cyc_wdata, input, DATA_W, current cycle's address and write data.
REQ-012 Ports cyc_cond_check / cond_true, input / input, 1 / 1, conditional-branch request and evaluated condition.
REQ-013 Ports addr_bus, output, ADDR_W and wdata, output, DATA_W, registered bus address and write data.
REQ-014 Ports drive_data / mem_req_read / mem_req_write, output, 1 each, bus drive enable and memory requests.
REQ-015 Ports mem_ready / rdata, input, 1 / DATA_W, memory ready and read data.
REQ-016 Ports rdata_valid / rdata_q, output, 1 / DATA_W, captured read data strobe and value.
REQ-017 Ports t_phase / instr_done, output, 3 / 1, current T-state (0=T1) and completion pulse.

Function
REQ-018 States IDLE and RUN; instr_ready SHALL be 1 only in IDLE.
REQ-019 In IDLE, instr_valid=1 SHALL latch the count and enter RUN with cycle_idx=0 and t_phase=0 on the next edge.
REQ-020 A count of 0 SHALL be treated as 1; a count above MAX_CYCLES SHALL be clamped to MAX_CYCLES.
REQ-021 At T1, addr_bus SHALL load cyc_addr.
REQ-022 At T2, READ SHALL set mem_req_read=1 and drive_data=0.
REQ-023 At T2, WRITE SHALL set mem_req_write=1, drive_data=1 and wdata=cyc_wdata.
REQ-024 At T2, NONE SHALL leave both requests at 0.
REQ-025 At T3 of a READ with mem_ready=1, rdata_q SHALL capture rdata and rdata_valid SHALL pulse for exactly one clk.
REQ-026 At T3 of a READ or WRITE with mem_ready=0, t_phase SHALL hold at T3 (wait state), with requests and addr_bus held stable.
REQ-027 Phases T4..T_PER_M-2 are extension states that SHALL hold all bus outputs unchanged.
REQ-028 At the final phase (T_PER_M-1), mem_req_read, mem_req_write and drive_data SHALL clear.
REQ-029 At the final phase, if cyc_cond_check=1 and cond_true=0, cycle_idx SHALL jump to MAX_CYCLES-1; a jump from MAX_CYCLES-1 itself completes the instruction.
REQ-030 Otherwise at the final phase, if cycle_idx equals latched count-1 (or MAX_CYCLES-1), the instruction completes; if not, cycle_idx SHALL increment and t_phase SHALL return to 0.
REQ-031 On completion, instr_done SHALL pulse one clk on the same edge that returns the FSM to IDLE; the earliest next accept is the following edge.
REQ-032 Latency with no wait states SHALL be N*T_PER_M clk from accept to instr_done for an N-cycle instruction.
REQ-033 instr_valid in RUN SHALL be ignored.

Reset
REQ-034 reset SHALL force IDLE, cycle_idx=0, t_phase=0, addr_bus=0, wdata=0, rdata_q=0, and all request, strobe and done outputs to 0, including mid-cycle and during wait states.
REQ-035 On the edge reset deasserts, instr_ready SHALL be 1.

Configuration
REQ-036 Macro BCE_WAIT_STATE_EN, when defined, SHALL enable the mem_ready stall of REQ-026.
REQ-037 When BCE_WAIT_STATE_EN is undefined, mem_ready SHALL be ignored (treated as 1), T3 SHALL never stall, and REQ-025 capture SHALL occur unconditionally at T3.

Verification
REQ-038 3-cycle instruction (READ 0x0100, WRITE 0xC000 data 0x5A, NONE), mem_ready=1 -> req pulses in order, rdata_valid once, instr_done exactly 12 clk after accept.
REQ-039 READ 0x0150 with mem_ready low for 3 clk at T3 (BCE_WAIT_STATE_EN defined) -> t_phase holds 2 for 3 clk, addr_bus stays 0x0150, instr_done delayed 3 clk.
REQ-040 Same stimulus as REQ-039 without BCE_WAIT_STATE_EN -> no stall, done at nominal latency.
REQ-041 Count 5, cycle 1 has cyc_cond_check=1 and cond_true=0 (MAX_CYCLES=6) -> cycle_idx sequence 0,1,5, done after 12 clk.
REQ-042 reset asserted at T2 of a WRITE -> next edge: requests 0, drive_data 0, IDLE, instr_ready 1.
REQ-043 Count 0 and count 9 (MAX_CYCLES=6) -> run 1 and 6 M-cycles respectively; back-to-back accept occurs one clk after instr_done.
